// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer: default width, bit-counter width
// function and a counter type wide enough for any legal N (2..64).
package sipo_pkg;

    localparam int SIPO_N_DEFAULT = 8;
    localparam int SIPO_CNT_MAX_W = 7;

    typedef logic [SIPO_CNT_MAX_W-1:0] sipo_cnt_t;

    // Wide enough to hold the value N, which the parity build needs for its extra bit.
    function automatic int sipo_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sipo_holding_reg.sv
// Valid/ready output holding register: loads a completed word when empty or
// draining, otherwise drops it and pulses overrun for one cycle.
module sipo_holding_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         overrun
);

    logic [W-1:0] data_reg;
    logic [W-1:0] data_next;
    logic         valid_reg;
    logic         valid_next;
    logic         overrun_reg;
    logic         overrun_next;
    logic         drain;

    assign drain = valid_reg && ready;

    always_comb begin
        data_next    = data_reg;
        valid_next   = valid_reg;
        overrun_next = 1'b0;
        if (load_valid && (!valid_reg || drain)) begin
            data_next  = load_data;
            valid_next = 1'b1;
        end else if (load_valid) begin
            // Consumer is stalled on an older word: keep it, lose the new one.
            overrun_next = 1'b1;
        end else if (drain) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    assign data    = data_reg;
    assign valid   = valid_reg;
    assign overrun = overrun_reg;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer, MSB first, with valid/ready output.
// Define SIPO_DESERIALIZER_PARITY_EN for N data bits + even parity bit per frame.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int N     = SIPO_N_DEFAULT,
    parameter int CNT_W = sipo_cnt_width(N)
) (
    input  logic         CLK,
    input  logic         ASYNCRESETN,
    input  logic         SI,
    input  logic         SI_VALID,
    output logic [N-1:0] O,
    output logic         O_VALID,
    input  logic         O_READY,
    output logic         OVERRUN
`ifdef SIPO_DESERIALIZER_PARITY_EN
    ,
    output logic         PARITY_ERR
`endif
);

`ifdef SIPO_DESERIALIZER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int        FRAME_BITS = N + PAR_BITS;
    // Only the bits before the completing one need storage.
    localparam int        SH_W       = FRAME_BITS - 1;
    localparam int        HOLD_W     = N + PAR_BITS;
    localparam sipo_cnt_t LAST_IDX   = sipo_cnt_t'(FRAME_BITS - 1);

    logic [SH_W-1:0]   shreg_reg;
    logic [SH_W-1:0]   shreg_shift;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic              last_bit;
    logic              word_done;
    logic [HOLD_W-1:0] load_word;
    logic [HOLD_W-1:0] hold_data;

    genvar gi;

    assign shreg_shift[0] = SI;
    generate
        for (gi = 1; gi < SH_W; gi++) begin : g_shift
            assign shreg_shift[gi] = shreg_reg[gi-1];
        end
    endgenerate

    assign last_bit  = (sipo_cnt_t'(cnt_reg) == LAST_IDX);
    assign word_done = SI_VALID && last_bit;

    always_comb begin
        cnt_next = cnt_reg;
        if (SI_VALID) begin
            cnt_next = last_bit ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            shreg_reg <= '0;
            cnt_reg   <= '0;
        end else if (SI_VALID) begin
            shreg_reg <= shreg_shift;
            cnt_reg   <= cnt_next;
        end
    end

`ifdef SIPO_DESERIALIZER_PARITY_EN
    // Parity error rides in the holding register so it stays paired with O.
    assign load_word = {^{shreg_reg, SI}, shreg_reg};
`else
    assign load_word = {shreg_reg, SI};
`endif

    sipo_holding_reg #(
        .W (HOLD_W)
    ) u_hold (
        .clk        (CLK),
        .rst_n      (ASYNCRESETN),
        .load_valid (word_done),
        .load_data  (load_word),
        .ready      (O_READY),
        .data       (hold_data),
        .valid      (O_VALID),
        .overrun    (OVERRUN)
    );

    assign O = hold_data[N-1:0];
`ifdef SIPO_DESERIALIZER_PARITY_EN
    assign PARITY_ERR = hold_data[N];
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer at N=4 with a scoreboard of expected
// words; also exercises PARITY_ERR when SIPO_DESERIALIZER_PARITY_EN is defined.
module tb_sipo_deserializer;

    localparam int N = 4;

    logic         CLK;
    logic         ASYNCRESETN;
    logic         SI;
    logic         SI_VALID;
    logic [N-1:0] O;
    logic         O_VALID;
    logic         O_READY;
    logic         OVERRUN;
`ifdef SIPO_DESERIALIZER_PARITY_EN
    logic         PARITY_ERR;
`endif

    int           checks;
    int           errors;
    logic [N-1:0] sb[$];
    logic [N-1:0] exp_word;

    sipo_deserializer #(.N(N)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .SI          (SI),
        .SI_VALID    (SI_VALID),
        .O           (O),
        .O_VALID     (O_VALID),
        .O_READY     (O_READY),
        .OVERRUN     (OVERRUN)
`ifdef SIPO_DESERIALIZER_PARITY_EN
        ,
        .PARITY_ERR  (PARITY_ERR)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive inputs just after an edge, run to the next edge, then settle 1 time unit.
    task automatic step(input logic v, input logic b, input logic rdy);
        SI_VALID = v;
        SI       = b;
        O_READY  = rdy;
        @(posedge CLK);
        #1;
    endtask

    // Sends one frame MSB first; the completing bit carries rdy_last.
    task automatic send_word(input logic [N-1:0] w, input logic rdy_mid,
                             input logic rdy_last, input logic par_flip);
`ifdef SIPO_DESERIALIZER_PARITY_EN
        for (int i = N - 1; i >= 0; i--) step(1'b1, w[i], rdy_mid);
        step(1'b1, (^w) ^ par_flip, rdy_last);
`else
        for (int i = N - 1; i > 0; i--) step(1'b1, w[i], rdy_mid);
        step(1'b1, w[0], rdy_last);
        if (par_flip) $display("note: par_flip ignored without parity");
`endif
    endtask

    task automatic pop_expected();
        if (sb.size() == 0) begin
            exp_word = 'x;
            $display("scoreboard underflow");
        end else begin
            exp_word = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        ASYNCRESETN = 1'b0;
        SI = 1'b0; SI_VALID = 1'b0; O_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (O !== '0) begin errors++; $display("FAIL reset_O got %h want 0", O); end
        checks++; if (O_VALID !== 1'b0) begin errors++; $display("FAIL reset_O_VALID got %b want 0", O_VALID); end
        checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_OVERRUN got %b want 0", OVERRUN); end
`ifdef SIPO_DESERIALIZER_PARITY_EN
        checks++; if (PARITY_ERR !== 1'b0) begin errors++; $display("FAIL reset_PARITY_ERR got %b want 0", PARITY_ERR); end
`endif
        ASYNCRESETN = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        sb.push_back(4'hB);
        send_word(4'hB, 1'b1, 1'b1, 1'b0);
        pop_expected();
        checks++; if (O_VALID !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", O_VALID); end
        checks++; if (O !== exp_word) begin errors++; $display("FAIL basic_O got %h want %h", O, exp_word); end
        step(1'b0, 1'b0, 1'b1);
        checks++; if (O_VALID !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", O_VALID); end
        checks++; if (O !== 4'hB) begin errors++; $display("FAIL basic_O_hold got %h want b", O); end
        $display("test_basic word=%h", exp_word);
    endtask

    task automatic test_gaps();
        sb.push_back(4'hC);
        step(1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        checks++; if (O_VALID !== 1'b0) begin errors++; $display("FAIL gaps_early_valid got %b want 0", O_VALID); end
`ifdef SIPO_DESERIALIZER_PARITY_EN
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
`else
        step(1'b1, 1'b0, 1'b1);
`endif
        pop_expected();
        checks++; if (O_VALID !== 1'b1) begin errors++; $display("FAIL gaps_valid got %b want 1", O_VALID); end
        checks++; if (O !== exp_word) begin errors++; $display("FAIL gaps_O got %h want %h", O, exp_word); end
        step(1'b0, 1'b0, 1'b1);
        $display("test_gaps word=%h", exp_word);
    endtask

    task automatic test_overrun();
        sb.push_back(4'hA);
        send_word(4'hA, 1'b0, 1'b0, 1'b0);
        pop_expected();
        checks++; if (O !== exp_word) begin errors++; $display("FAIL ovr_first_O got %h want %h", O, exp_word); end
        send_word(4'h5, 1'b0, 1'b0, 1'b0);
        checks++; if (OVERRUN !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b want 1", OVERRUN); end
        checks++; if (O !== 4'hA) begin errors++; $display("FAIL ovr_O_hold got %h want a", O); end
        step(1'b0, 1'b0, 1'b0);
        checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle got %b want 0", OVERRUN); end
        checks++; if (O_VALID !== 1'b1 || O !== 4'hA) begin errors++; $display("FAIL ovr_stall got v=%b O=%h want v=1 O=a", O_VALID, O); end
        step(1'b0, 1'b0, 1'b1);
        checks++; if (O_VALID !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b want 0", O_VALID); end
        $display("test_overrun held=%h", O);
    endtask

    task automatic test_ready_on_completion();
        sb.push_back(4'hC);
        send_word(4'hC, 1'b0, 1'b0, 1'b0);
        pop_expected();
        checks++; if (O !== exp_word) begin errors++; $display("FAIL roc_first_O got %h want %h", O, exp_word); end
        sb.push_back(4'h3);
        send_word(4'h3, 1'b0, 1'b1, 1'b0);
        pop_expected();
        checks++; if (O !== exp_word) begin errors++; $display("FAIL roc_O got %h want %h", O, exp_word); end
        checks++; if (O_VALID !== 1'b1) begin errors++; $display("FAIL roc_valid got %b want 1", O_VALID); end
        checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL roc_overrun got %b want 0", OVERRUN); end
        step(1'b0, 1'b0, 1'b1);
        $display("test_ready_on_completion word=%h", exp_word);
    endtask

    task automatic test_async_reset();
        sb.push_back(4'h6);
        send_word(4'h6, 1'b0, 1'b0, 1'b0);
        pop_expected();
        checks++; if (O !== exp_word) begin errors++; $display("FAIL ar_pre_O got %h want %h", O, exp_word); end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        checks++; if (O !== 4'h6) begin errors++; $display("FAIL ar_midword_visible got %h want 6", O); end
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        checks++; if (O_VALID !== 1'b0 || O !== '0 || OVERRUN !== 1'b0)
            begin errors++; $display("FAIL ar_async got v=%b O=%h ovr=%b want 0/0/0", O_VALID, O, OVERRUN); end
        @(posedge CLK);
        #1;
        ASYNCRESETN = 1'b1;
        sb.push_back(4'h9);
        send_word(4'h9, 1'b1, 1'b1, 1'b0);
        pop_expected();
        checks++; if (O !== exp_word || O_VALID !== 1'b1) begin errors++; $display("FAIL ar_after_O got %h v=%b want %h v=1", O, O_VALID, exp_word); end
        step(1'b0, 1'b0, 1'b1);
        $display("test_async_reset word=%h", exp_word);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] w;
        for (int k = 0; k < 8; k++) begin
            w = N'($urandom);
            sb.push_back(w);
            send_word(w, 1'b1, 1'b1, 1'b0);
            pop_expected();
            checks++; if (O !== exp_word || O_VALID !== 1'b1 || OVERRUN !== 1'b0)
                begin errors++; $display("FAIL b2b_%0d got O=%h v=%b ovr=%b want %h/1/0", k, O, O_VALID, OVERRUN, exp_word); end
            $display("b2b word %0d O=%h expected=%h", k, O, exp_word);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++; if (O_VALID !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", O_VALID); end
    endtask

`ifdef SIPO_DESERIALIZER_PARITY_EN
    task automatic test_parity();
        sb.push_back(4'hB);
        send_word(4'hB, 1'b1, 1'b1, 1'b0);
        pop_expected();
        checks++; if (O !== exp_word || PARITY_ERR !== 1'b0) begin errors++; $display("FAIL par_good got O=%h pe=%b want %h/0", O, PARITY_ERR, exp_word); end
        sb.push_back(4'hB);
        send_word(4'hB, 1'b1, 1'b1, 1'b1);
        pop_expected();
        checks++; if (O !== exp_word || PARITY_ERR !== 1'b1) begin errors++; $display("FAIL par_bad got O=%h pe=%b want %h/1", O, PARITY_ERR, exp_word); end
        step(1'b0, 1'b0, 1'b1);
        $display("test_parity pe=%b", PARITY_ERR);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_ready_on_completion();
        test_async_reset();
        test_back_to_back();
`ifdef SIPO_DESERIALIZER_PARITY_EN
        test_parity();
`endif
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in parallel-out deserializer. It is the receive-side counterpart of the team's PISO shift-register serializer. It accepts one bit per qualified cycle, MSB first, and assembles N-bit words. Each completed word is presented on a valid/ready holding register. It sits between a serial link (or PISO output) and word-wide consumer logic.

Parameters:
- N, 8, data word width in bits; legal range 2..64
- CNT_W, $clog2(N+1), bit-counter width; derived, not overridden

Ports:
- CLK  input  1  clock; all state updates on its rising edge
- ASYNCRESETN  input  1  asynchronous active-low reset
- SI  input  1  serial data bit
- SI_VALID  input  1  SI is sampled on this cycle when high
- O  output  N  assembled parallel word from the holding register
- O_VALID  output  1  holding register contains an unconsumed word
- O_READY  input  1  consumer accepts O when O_VALID && O_READY
- OVERRUN  output  1  one-cycle pulse when a completed word is dropped

Behaviour:
- Reset: CLK is the single clock; reset is asynchronous and active-low. While ASYNCRESETN=0, the following are all 0: shift register, bit count, O, O_VALID and OVERRUN. Release of reset takes effect at the next CLK edge; no partial word survives reset.
- Bit order: MSB first, matching the PISO. Each accepted bit is shifted in as {shreg[N-2:0], SI}. The first bit received of a word ends in O[N-1].
- Accept cycle (SI_VALID=1): shift in SI. The count increments from 0 through N-1.
- Completing bit (count==N-1 and SI_VALID=1): the full word {shreg[N-2:0], SI} is the completed word, and count wraps to 0 in the same edge.
- Idle cycle (SI_VALID=0): shreg and count hold.
- Holding-register update, evaluated per edge, with drain = O_VALID && O_READY:
  - Word completes and (!O_VALID or drain): load O with the new word; O_VALID=1 next cycle.
  - Word completes, O_VALID=1 and !O_READY: the new word is dropped, O holds, and OVERRUN=1 for exactly one cycle.
  - No completion and drain: O_VALID=0 next cycle; O holds its last value.
  - Otherwise: hold.
- Latency: the completing bit sampled at edge k gives O/O_VALID valid after edge k; the consumer sees it in cycle k+1.
- Back-to-back throughput: a word may complete every N cycles with no gaps, provided O_READY is high on the completion cycle.
- O is stable while O_VALID=1 and !O_READY.
- The shift-register contents mid-word are not visible on O.

Optional Feature:
- Macro: SIPO_DESERIALIZER_PARITY_EN
- Defined:
  - Each frame is N data bits followed by one even-parity bit. The count runs 0..N, so CNT_W covers N.
  - Completion occurs on the parity bit. O/O_VALID rules are unchanged.
  - Extra output PARITY_ERR (1 bit) is updated with every load: 1 if the XOR of the N data bits and the parity bit is 1.
  - PARITY_ERR is reset to 0 and held with O.
  - A dropped (overrun) frame does not update PARITY_ERR.
- Undefined: no PARITY_ERR port; frames are exactly N bits.

Decomposition:
- Shared package sipo_pkg holds:
  - the default N constant;
  - the CNT_W computation function;
  - the typedef for the bit counter.
- One natural sub-module: sipo_holding_reg. It is the valid/ready output register with load/drain/overrun logic, parameterised by width. The top keeps the shift register and bit counter.

Test Plan:
- N=4, reset released, send 1,0,1,1 on consecutive cycles with O_READY=1 -> O=4'b1011 and O_VALID=1 the cycle after the 4th bit; O_VALID drops the next cycle.
- N=4, SI_VALID gaps: send 1,(gap x3),1,0,(gap),0 -> O=4'b1100; the count does not advance during gaps.
- N=4, O_READY=0, send 0xA then 0x5 back to back -> O holds 0xA; OVERRUN pulses one cycle at the completion of 0x5. With O_READY=1 afterwards: 0xA is drained, O_VALID=0.
- N=4, O_READY asserted exactly on the completion cycle of word 0x3 while 0xC is held -> 0xC is drained, O=0x3 next cycle, O_VALID stays 1, no OVERRUN.
- N=4, assert ASYNCRESETN=0 between clock edges after 2 bits of a word -> O_VALID/O/OVERRUN go to 0 immediately. Then send 0x9 -> O=0x9, with no residue from the aborted bits.
- With SIPO_DESERIALIZER_PARITY_EN, N=4: send 1,0,1,1 then parity 1 -> O=0xB, PARITY_ERR=0. With parity 0 -> PARITY_ERR=1.
